// File: rtl/mux_bus_arbiter_rr8.sv
// Round-robin arbiter/sequencer for the shared 8-to-1 bus mux.
// Grants one owner at a time, bursts bounded by MAX_HOLD transfers.
module mux_bus_arbiter_rr8 #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] din,
  output logic [7:0]         grant,
  output logic [2:0]         sel,
  output logic               mux_en,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t           state, state_n;
  logic [7:0]       grant_n;
  logic [2:0]       sel_n;
  logic [WIDTH-1:0] dout_n;
  logic             valid_n;
  logic [3:0]       hold_cnt, hold_n;
  logic [2:0]       last_owner, last_n;

  logic [2:0] arb_ptr, arb_idx, cand;
  logic       arb_found;
  logic       xfer, last_xfer, rel;

  // In IDLE the pointer follows last_owner; on release it is owner+1.
  always_comb begin
    arb_ptr   = (state == S_IDLE) ? last_owner + 3'd1 : sel + 3'd1;
    arb_found = 1'b0;
    arb_idx   = arb_ptr;
    cand      = arb_ptr;
    for (int i = 7; i >= 0; i--) begin
      cand = arb_ptr + 3'(i);
      if (req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign xfer      = (state == S_GRANT) && req[sel];
  assign last_xfer = xfer && ((hold_cnt + 4'd1) == HOLD_MAX);
  assign rel       = (state == S_GRANT) && (!req[sel] || last_xfer);

  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n   = sel;
    dout_n  = dout;
    valid_n = 1'b0;
    hold_n  = hold_cnt;
    last_n  = last_owner;
    unique case (state)
      S_IDLE: begin
        if (arb_found) begin
          state_n = S_GRANT;
          grant_n = 8'b1 << arb_idx;
          sel_n   = arb_idx;
          hold_n  = 4'd0;
        end
      end
      S_GRANT: begin
        if (xfer) begin
          dout_n  = din[sel*WIDTH +: WIDTH];
          valid_n = 1'b1;
          hold_n  = hold_cnt + 4'd1;
        end
        if (rel) begin
          last_n = sel;
          hold_n = 4'd0;
          if (arb_found) begin
            grant_n = 8'b1 << arb_idx;
            sel_n   = arb_idx;
          end else begin
            state_n = S_IDLE;
            grant_n = 8'd0;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        grant_n = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= 8'd0;
      sel        <= 3'd0;
      dout       <= '0;
      dout_valid <= 1'b0;
      hold_cnt   <= 4'd0;
      last_owner <= 3'd7;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      sel        <= sel_n;
      dout       <= dout_n;
      dout_valid <= valid_n;
      hold_cnt   <= hold_n;
      last_owner <= last_n;
    end
  end

  assign mux_en = |grant;

endmodule

// File: tb/tb_mux_bus_arbiter_rr8.sv
// Directed vector bench for mux_bus_arbiter_rr8.
// Table of per-cycle records plus hand sequences for corner cases.
module tb_mux_bus_arbiter_rr8;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   req;
  logic [127:0] din;
  logic [7:0]   grant;
  logic [2:0]   sel;
  logic         mux_en;
  logic [15:0]  dout;
  logic         dout_valid;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic [7:0]  req;
    logic [7:0]  grant;
    logic [2:0]  sel;
    logic        valid;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  mux_bus_arbiter_rr8 #(.WIDTH(16), .MAX_HOLD(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .din(din),
    .grant(grant),
    .sel(sel),
    .mux_en(mux_en),
    .dout(dout),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q);
    reset = r;
    req   = q;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g,
                         input logic [2:0] s, input logic v,
                         input logic [15:0] d);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".sel"}, 32'(sel), 32'(s));
    chk({tag, ".mux_en"}, 32'(mux_en), 32'(|g));
    chk({tag, ".valid"}, 32'(dout_valid), 32'(v));
    chk({tag, ".dout"}, 32'(dout), 32'(d));
  endtask

  function automatic vec_t mk(input logic r, input logic [7:0] q,
                              input logic [7:0] g, input logic [2:0] s,
                              input logic v, input logic [15:0] d);
    vec_t x;
    x.rst = r; x.req = q; x.grant = g;
    x.sel = s; x.valid = v; x.dout = d;
    return x;
  endfunction

  initial begin
    int o, c, nx;
    reset = 1'b1;
    req   = 8'h00;
    for (int i = 0; i < 8; i++) din[i*16 +: 16] = 16'h1000 + 16'(i);

    // all requesting: 0..7 then wrap to 0, four words each
    vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 8'hFF, 8'h01, 0, 0, 16'h0000));
    for (int n = 0; n < 36; n++) begin
      o  = (n / 4) % 8;
      c  = n % 4;
      nx = (c == 3) ? (o + 1) % 8 : o;
      vecs.push_back(mk(0, 8'hFF, 8'(1 << nx), 3'(nx), 1,
                        16'h1000 + 16'(o)));
    end
    // owner 7 releases, pointer wraps: 3 before 6
    vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 8'h80, 8'h80, 7, 0, 16'h0000));
    vecs.push_back(mk(0, 8'h80, 8'h80, 7, 1, 16'h1007));
    vecs.push_back(mk(0, 8'h48, 8'h08, 3, 0, 16'h1007));
    vecs.push_back(mk(0, 8'h48, 8'h08, 3, 1, 16'h1003));
    vecs.push_back(mk(0, 8'h40, 8'h40, 6, 0, 16'h1003));
    // owner 0 drops after two words, 5 takes over, then idle
    vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 8'h21, 8'h01, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 8'h21, 8'h01, 0, 1, 16'h1000));
    vecs.push_back(mk(0, 8'h21, 8'h01, 0, 1, 16'h1000));
    vecs.push_back(mk(0, 8'h20, 8'h20, 5, 0, 16'h1000));
    vecs.push_back(mk(0, 8'h20, 8'h20, 5, 1, 16'h1005));
    vecs.push_back(mk(0, 8'h00, 8'h00, 5, 0, 16'h1005));

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req);
      chk_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel,
              vecs[i].valid, vecs[i].dout);
    end

    // idle for 10 cycles: nothing moves, dout keeps last word
    for (int i = 0; i < 10; i++) begin
      step(0, 8'h00);
      chk_out($sformatf("idle%0d", i), 8'h00, 3'd5, 0, 16'h1005);
    end

    // single requester: back-to-back re-grant, no valid gap
    din[15:0] = 16'hA5A5;
    step(1, 8'h00);
    chk_out("solo_rst", 8'h00, 3'd0, 0, 16'h0000);
    step(0, 8'h01);
    chk_out("solo_g", 8'h01, 3'd0, 0, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      step(0, 8'h01);
      chk_out($sformatf("solo%0d", i), 8'h01, 3'd0, 1, 16'hA5A5);
    end

    // reset mid-burst of owner 2, then priority restarts at 0
    step(1, 8'h00);
    step(0, 8'h04);
    chk_out("mb_g", 8'h04, 3'd2, 0, 16'h0000);
    step(0, 8'h04);
    step(0, 8'h04);
    chk_out("mb_x2", 8'h04, 3'd2, 1, 16'h1002);
    step(1, 8'h04);
    chk_out("mb_rst", 8'h00, 3'd0, 0, 16'h0000);
    step(0, 8'h84);
    chk_out("mb_after", 8'h04, 3'd2, 0, 16'h0000);
    step(0, 8'h84);
    chk_out("mb_x", 8'h04, 3'd2, 1, 16'h1002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
